// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide sequencer: operation codes,
// sequencer states and the busy-counter width.
package md_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } md_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_e;

    // Ops 2/3 are the divides.
    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    // Ops 0/2 treat their operands as two's complement.
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational arithmetic core: 64-bit product for mult/multu and
// quotient/remainder for div/divu. Signed divide works on magnitudes and
// restores signs afterwards, so 0x80000000 / -1 naturally yields 0x80000000
// with a zero remainder. A zero divisor is replaced by 1 internally to keep
// the divider well defined; the caller discards the result via div_zero.
import md_pkg::*;

module md_arith (
    input  logic [1:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_zero
);

    logic        signed_s;
    logic        is_div_s;
    logic        neg_a_s;
    logic        neg_b_s;
    logic        neg_q_s;
    logic [63:0] mul_a_s;
    logic [63:0] mul_b_s;
    logic [63:0] prod_s;
    logic [31:0] mag_a_s;
    logic [31:0] mag_b_s;
    logic [31:0] divisor_s;
    logic [31:0] quo_s;
    logic [31:0] rem_s;
    logic [31:0] quo_fix_s;
    logic [31:0] rem_fix_s;

    // Shared multiplier and magnitude divider, then result selection by op.
    always_comb begin
        signed_s  = op_is_signed(md_op);
        is_div_s  = op_is_div(md_op);

        // One 64x64 multiplier; signedness only changes the operand extension.
        mul_a_s   = {{32{signed_s & rs_val[31]}}, rs_val};
        mul_b_s   = {{32{signed_s & rt_val[31]}}, rt_val};
        prod_s    = mul_a_s * mul_b_s;

        // Divide on magnitudes; quotient sign is XOR of operand signs,
        // remainder follows the dividend.
        neg_a_s   = signed_s & rs_val[31];
        neg_b_s   = signed_s & rt_val[31];
        neg_q_s   = neg_a_s ^ neg_b_s;
        mag_a_s   = neg_a_s ? (32'd0 - rs_val) : rs_val;
        mag_b_s   = neg_b_s ? (32'd0 - rt_val) : rt_val;
        div_zero  = is_div_s & (rt_val == 32'd0);
        divisor_s = (rt_val == 32'd0) ? 32'd1 : mag_b_s;
        quo_s     = mag_a_s / divisor_s;
        rem_s     = mag_a_s % divisor_s;
        quo_fix_s = neg_q_s ? (32'd0 - quo_s) : quo_s;
        rem_fix_s = neg_a_s ? (32'd0 - rem_s) : rem_s;

        case (md_op)
            MD_MULT, MD_MULTU: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            MD_DIV, MD_DIVU: begin
                res_hi = rem_fix_s;
                res_lo = quo_fix_s;
            end
            default: begin
                res_hi = 32'd0;
                res_lo = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/md_stall_ctrl.sv
// Multiply/divide sequencer and decode-stall controller. The result is
// computed in the launch cycle and parked in hi_p/lo_p; a down-counter then
// models the unit latency and the parked value is committed to HI/LO on the
// same edge that busy falls. HI/LO are never bypassed from the parked value.
import md_pkg::*;

module md_stall_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic        md_use_D,
    output logic        busy,
    output logic        stall_D,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      hi_p_q, hi_p_d;
    logic [31:0]      lo_p_q, lo_p_d;
    logic             dz_q, dz_d;

    logic [31:0]      arith_hi_s;
    logic [31:0]      arith_lo_s;
    logic             arith_dz_s;

    md_arith u_arith (
        .md_op    (md_op),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .res_hi   (arith_hi_s),
        .res_lo   (arith_lo_s),
        .div_zero (arith_dz_s)
    );

    // Next-state, counter, pending-result and HI/LO update logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        hi_p_d  = hi_p_q;
        lo_p_d  = lo_p_q;
        dz_d    = dz_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    hi_p_d  = arith_hi_s;
                    lo_p_d  = arith_lo_s;
                    dz_d    = arith_dz_s;
                    cnt_d   = op_is_div(md_op) ? DIV_CNT : MULT_CNT;
                    state_d = BUSY;
                end else begin
                    // mthi/mtlo only land while the unit is idle and not launching.
                    if (wr_hi) begin
                        hi_d = rs_val;
                    end else begin
                        hi_d = hi_q;
                    end
                    if (wr_lo) begin
                        lo_d = rs_val;
                    end else begin
                        lo_d = lo_q;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = IDLE;
                    // A divide by zero leaves HI/LO untouched.
                    if (!dz_q) begin
                        hi_d = hi_p_q;
                        lo_d = lo_p_q;
                    end else begin
                        hi_d = hi_q;
                        lo_d = lo_q;
                    end
                end else begin
                    state_d = BUSY;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase

        busy_d = (state_d == BUSY);
    end

    // State, counter and register file flops; reset aborts any operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= CNT_ZERO;
            busy_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            hi_p_q  <= 32'd0;
            lo_p_q  <= 32'd0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            hi_p_q  <= hi_p_d;
            lo_p_q  <= lo_p_d;
            dz_q    <= dz_d;
        end
    end

    assign busy    = busy_q;
    assign hi      = hi_q;
    assign lo      = lo_q;
    // Combinational so the D stage is also held in the launch cycle.
    assign stall_D = md_use_D & (start | busy_q);

endmodule

// File: tb/tb_md_stall_ctrl.sv
// Self-checking bench for md_stall_ctrl: directed scenarios plus a randomized
// run compared cycle by cycle against a reference model built from the
// architectural rules (absolute cycle numbers and plain integer arithmetic).
module tb_md_stall_ctrl;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        wr_hi;
    logic        wr_lo;
    logic        md_use_D;
    logic        busy;
    logic        stall_D;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: edge count since reset, edge at which the current
    // operation completes, architectural HI/LO and the pending result.
    int unsigned ecyc;
    int unsigned done_at;
    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    bit          m_pdz;

    always #5 clk = ~clk;

    md_stall_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op),
        .rs_val(rs_val), .rt_val(rt_val), .wr_hi(wr_hi), .wr_lo(wr_lo),
        .md_use_D(md_use_D), .busy(busy), .stall_D(stall_D), .hi(hi), .lo(lo)
    );

    function automatic bit m_busy();
        return ecyc < done_at;
    endfunction

    // MIPS mult/div semantics from 64-bit integer arithmetic.
    function automatic void md_ref(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output bit dz, output logic [31:0] rh, output logic [31:0] rl);
        longint      sa, sb;
        logic [63:0] ua, ub, w, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        dz = 1'b0;
        rh = 32'd0;
        rl = 32'd0;
        case (op)
            2'd0: begin w = sa * sb; rh = w[63:32]; rl = w[31:0]; end
            2'd1: begin w = ua * ub; rh = w[63:32]; rl = w[31:0]; end
            2'd2: begin
                if (b == 32'd0) dz = 1'b1;
                else begin q = sa / sb; r = sa % sb; rl = q[31:0]; rh = r[31:0]; end
            end
            default: begin
                if (b == 32'd0) dz = 1'b1;
                else begin q = ua / ub; r = ua % ub; rl = q[31:0]; rh = r[31:0]; end
            end
        endcase
    endfunction

    task automatic model_clear();
        ecyc = 0; done_at = 0; m_hi = 32'd0; m_lo = 32'd0;
        m_phi = 32'd0; m_plo = 32'd0; m_pdz = 1'b0;
    endtask

    // Advance one clock edge, update the model, and land 2ns after the edge.
    task automatic step();
        bit was_busy;
        @(posedge clk);
        if (reset) begin
            model_clear();
        end else begin
            was_busy = m_busy();
            ecyc = ecyc + 1;
            if (was_busy) begin
                if (ecyc == done_at && !m_pdz) begin m_hi = m_phi; m_lo = m_plo; end
            end else if (start) begin
                md_ref(md_op, rs_val, rt_val, m_pdz, m_phi, m_plo);
                done_at = ecyc + (md_op[1] ? DC : MC);
            end else begin
                if (wr_hi) m_hi = rs_val;
                if (wr_lo) m_lo = rs_val;
            end
        end
        #2;
    endtask

    task automatic idle_in();
        start = 1'b0; md_op = 2'd0; rs_val = 32'd0; rt_val = 32'd0; wr_hi = 1'b0; wr_lo = 1'b0;
    endtask

    // Launch one operation and measure busy length and stall behaviour.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic use_d,
                          output int nb, output int nstall, output logic stall_after);
        idle_in();
        md_use_D = use_d; start = 1'b1; md_op = op; rs_val = a; rt_val = b;
        #1;
        nstall = (stall_D === 1'b1) ? 1 : 0;
        step();
        idle_in();
        nb = 0;
        while (busy === 1'b1 && nb < 40) begin
            #1;
            if (stall_D === 1'b1) nstall++;
            nb++;
            step();
        end
        #1;
        stall_after = stall_D;
    endtask

    task automatic test_reset();
        reset = 1'b1; md_use_D = 1'b1; idle_in();
        step(); step();
        reset = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (hi !== 32'd0) begin n_bad++; $display("FAIL reset_hi: got %h want 0", hi); end
        n_cmp++; if (lo !== 32'd0) begin n_bad++; $display("FAIL reset_lo: got %h want 0", lo); end
        n_cmp++; if (stall_D !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", stall_D); end
    endtask

    task automatic test_mult();
        int nb, ns; logic sa;
        run_op(2'd0, 32'hFFFFFFFE, 32'd3, 1'b0, nb, ns, sa);
        n_cmp++; if (nb != MC) begin n_bad++; $display("FAIL mult_busy_len: got %0d want %0d", nb, MC); end
        n_cmp++; if (ns != 0) begin n_bad++; $display("FAIL mult_nostall: got %0d want 0", ns); end
        n_cmp++; if (hi !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
        n_cmp++; if (lo !== 32'hFFFFFFFA) begin n_bad++; $display("FAIL mult_lo: got %h want fffffffa", lo); end
    endtask

    task automatic test_div();
        int nb, ns; logic sa;
        run_op(2'd2, 32'hFFFFFFF9, 32'd2, 1'b0, nb, ns, sa);
        n_cmp++; if (nb != DC) begin n_bad++; $display("FAIL div_busy_len: got %0d want %0d", nb, DC); end
        n_cmp++; if (lo !== 32'hFFFFFFFD) begin n_bad++; $display("FAIL div_lo: got %h want fffffffd", lo); end
        n_cmp++; if (hi !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL div_hi: got %h want ffffffff", hi); end
        run_op(2'd3, 32'd7, 32'd2, 1'b0, nb, ns, sa);
        n_cmp++; if (lo !== 32'd3) begin n_bad++; $display("FAIL divu_lo: got %h want 3", lo); end
        n_cmp++; if (hi !== 32'd1) begin n_bad++; $display("FAIL divu_hi: got %h want 1", hi); end
    endtask

    task automatic test_stall();
        int nb, ns; logic sa;
        run_op(2'd0, 32'd5, 32'd6, 1'b1, nb, ns, sa);
        n_cmp++; if (ns != MC + 1) begin n_bad++; $display("FAIL stall_cycles: got %0d want %0d", ns, MC + 1); end
        n_cmp++; if (sa !== 1'b0) begin n_bad++; $display("FAIL stall_release: got %b want 0", sa); end
        n_cmp++; if (lo !== 32'd30) begin n_bad++; $display("FAIL stall_mult_lo: got %h want 1e", lo); end
        run_op(2'd0, 32'd5, 32'd6, 1'b0, nb, ns, sa);
        n_cmp++; if (ns != 0) begin n_bad++; $display("FAIL stall_unused: got %0d want 0", ns); end
    endtask

    task automatic test_divzero_mthi();
        int nb;
        idle_in(); md_use_D = 1'b0;
        wr_hi = 1'b1; rs_val = 32'h1234; step();
        idle_in(); wr_lo = 1'b1; rs_val = 32'h5678; step();
        idle_in();
        n_cmp++; if (hi !== 32'h1234) begin n_bad++; $display("FAIL mthi: got %h want 1234", hi); end
        n_cmp++; if (lo !== 32'h5678) begin n_bad++; $display("FAIL mtlo: got %h want 5678", lo); end
        start = 1'b1; md_op = 2'd2; rs_val = 32'd99; rt_val = 32'd0; step();
        idle_in();
        nb = (busy === 1'b1) ? 1 : 0;
        wr_lo = 1'b1; rs_val = 32'hDEAD; step();
        idle_in();
        while (busy === 1'b1 && nb < 40) begin nb++; step(); end
        n_cmp++; if (nb != DC) begin n_bad++; $display("FAIL divzero_busy_len: got %0d want %0d", nb, DC); end
        n_cmp++; if (hi !== 32'h1234) begin n_bad++; $display("FAIL divzero_hi: got %h want 1234", hi); end
        n_cmp++; if (lo !== 32'h5678) begin n_bad++; $display("FAIL divzero_lo: got %h want 5678", lo); end
        wr_hi = 1'b1; wr_lo = 1'b1; rs_val = 32'hCAFE; step();
        idle_in();
        n_cmp++; if (hi !== 32'hCAFE || lo !== 32'hCAFE) begin n_bad++; $display("FAIL mthi_mtlo_both: got %h/%h want cafe/cafe", hi, lo); end
        start = 1'b1; md_op = 2'd0; rs_val = 32'd2; rt_val = 32'd3; wr_hi = 1'b1; step();
        idle_in();
        n_cmp++; if (hi !== 32'hCAFE) begin n_bad++; $display("FAIL mthi_with_start: got %h want cafe", hi); end
        nb = 0;
        while (busy === 1'b1 && nb < 40) begin nb++; step(); end
        n_cmp++; if (lo !== 32'd6) begin n_bad++; $display("FAIL mult_after_mthi: got %h want 6", lo); end
    endtask

    task automatic test_async_reset();
        int nb, ns; logic sa;
        idle_in(); md_use_D = 1'b0;
        wr_hi = 1'b1; wr_lo = 1'b1; rs_val = 32'hAAAA; step();
        idle_in();
        start = 1'b1; md_op = 2'd2; rs_val = 32'd100; rt_val = 32'd7; step();
        idle_in(); step(); step();
        #1; reset = 1'b1; #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL areset_busy: got %b want 0", busy); end
        n_cmp++; if (hi !== 32'd0 || lo !== 32'd0) begin n_bad++; $display("FAIL areset_hilo: got %h/%h want 0/0", hi, lo); end
        model_clear();
        #1; reset = 1'b0;
        for (int i = 0; i < 12; i++) step();
        n_cmp++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin n_bad++; $display("FAIL areset_nocommit: got busy %b hi %h lo %h want 0/0/0", busy, hi, lo); end
        run_op(2'd1, 32'h10000, 32'h10000, 1'b0, nb, ns, sa);
        n_cmp++; if (nb != MC || hi !== 32'd1 || lo !== 32'd0) begin n_bad++; $display("FAIL areset_restart: got len %0d hi %h lo %h want %0d/1/0", nb, hi, lo, MC); end
    endtask

    task automatic test_overflow();
        int nb, ns; logic sa;
        run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, nb, ns, sa);
        n_cmp++; if (lo !== 32'h80000000) begin n_bad++; $display("FAIL ovf_div_lo: got %h want 80000000", lo); end
        n_cmp++; if (hi !== 32'd0) begin n_bad++; $display("FAIL ovf_div_hi: got %h want 0", hi); end
        run_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, nb, ns, sa);
        n_cmp++; if (hi !== 32'hFFFFFFFE) begin n_bad++; $display("FAIL multu_max_hi: got %h want fffffffe", hi); end
        n_cmp++; if (lo !== 32'd1) begin n_bad++; $display("FAIL multu_max_lo: got %h want 1", lo); end
    endtask

    task automatic test_random();
        logic exp_stall;
        for (int i = 0; i < 500; i++) begin
            start  = ($urandom_range(0, 5) == 0);
            md_op  = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 9))
                0: rs_val = 32'h80000000;
                1: rs_val = 32'($urandom_range(0, 20));
                default: rs_val = $urandom;
            endcase
            case ($urandom_range(0, 9))
                0: rt_val = 32'd0;
                1: rt_val = 32'hFFFFFFFF;
                2: rt_val = 32'($urandom_range(1, 9));
                default: rt_val = $urandom;
            endcase
            wr_hi    = ($urandom_range(0, 7) == 0);
            wr_lo    = ($urandom_range(0, 7) == 0);
            md_use_D = 1'($urandom_range(0, 1));
            #1;
            exp_stall = md_use_D & (start | m_busy());
            n_cmp++; if (stall_D !== exp_stall) begin n_bad++; $display("FAIL rnd_stall[%0d]: got %b want %b", i, stall_D, exp_stall); end
            step();
            n_cmp++; if (busy !== m_busy()) begin n_bad++; $display("FAIL rnd_busy[%0d]: got %b want %b", i, busy, m_busy()); end
            n_cmp++; if (hi !== m_hi) begin n_bad++; $display("FAIL rnd_hi[%0d]: got %h want %h", i, hi, m_hi); end
            n_cmp++; if (lo !== m_lo) begin n_bad++; $display("FAIL rnd_lo[%0d]: got %h want %h", i, lo, m_lo); end
        end
        idle_in();
    endtask

    initial begin
        model_clear();
        test_reset();
        test_mult();
        test_div();
        test_stall();
        test_divzero_mthi();
        test_async_reset();
        test_overflow();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d mismatched %0d", n_cmp, n_bad);
        $fatal(1);
    end

endmodule
